// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: owns the PC, drives a combinational instruction
// memory and buffers {instruction, PC+step} pairs toward decode in a small FIFO.
// A redirect reloads the PC and empties the queue in a single cycle.
module if_fetch_queue #(
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(4)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         redirect_valid,
    input  logic [ADDR_W-1:0]            redirect_pc,
    output logic [ADDR_W-1:0]            imem_addr,
    input  logic [DATA_W-1:0]            imem_rdata,
    input  logic                         id_ready,
    output logic                         id_valid,
    output logic [DATA_W-1:0]            id_instr,
    output logic [ADDR_W-1:0]            id_pc_plus4,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [ADDR_W-1:0] pc_q, pc_d, pc_next;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] instr_q [DEPTH];
    logic [DATA_W-1:0] instr_d [DEPTH];
    logic [ADDR_W-1:0] pc4_q [DEPTH];
    logic [ADDR_W-1:0] pc4_d [DEPTH];
    logic              push, pop;

    assign pc_next   = pc_q + PC_STEP;
    assign imem_addr = pc_q;
    assign count     = count_q;

    // Decode-side view of the head entry; a redirect hides it immediately.
    always_comb begin
        id_valid    = (count_q != '0) && !redirect_valid;
        id_instr    = '0;
        id_pc_plus4 = '0;
        if (count_q != '0) begin
            id_instr    = instr_q[rd_ptr_q];
            id_pc_plus4 = pc4_q[rd_ptr_q];
        end
    end

    // Next-state: push/pop bookkeeping, redirect overrides everything.
    always_comb begin
        pop      = id_valid && id_ready;
        // A full queue can still accept a fetch when the head leaves this cycle.
        push     = !redirect_valid && ((count_q != CNT_W'(DEPTH)) || pop);
        pc_d     = pc_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        instr_d  = instr_q;
        pc4_d    = pc4_q;
        if (redirect_valid) begin
            // Stale entries are left in place; count=0 makes them invisible.
            pc_d     = redirect_pc;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                instr_d[wr_ptr_q] = imem_rdata;
                pc4_d[wr_ptr_q]   = pc_next;
                wr_ptr_d          = wr_ptr_q + PTR_W'(1);
                pc_d              = pc_next;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q     <= RESET_PC;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            instr_q  <= '{default: '0};
            pc4_q    <= '{default: '0};
        end else begin
            pc_q     <= pc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            instr_q  <= instr_d;
            pc4_q    <= pc4_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: stimulus pushes the fetch PCs that decode
// should accept into a scoreboard; a negedge monitor checks every handshake.
module tb_if_fetch_queue;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc_plus4;
    logic [2:0]  count;

    int checks;
    int failures;
    logic [31:0] exp_q[$];

    if_fetch_queue #(
        .DATA_W  (32),
        .ADDR_W  (32),
        .DEPTH   (4),
        .RESET_PC(32'h0),
        .PC_STEP (32'h4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .id_ready      (id_ready),
        .id_valid      (id_valid),
        .id_instr      (id_instr),
        .id_pc_plus4   (id_pc_plus4),
        .count         (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    // Combinational instruction memory with address-derived contents.
    assign imem_rdata = mem_word(imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    task automatic sb_drained(input string name);
        chk(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    // Monitor: compare every accepted head entry against the scoreboard.
    always @(negedge clk) begin
        if (rst && id_valid && id_ready) begin
            logic [31:0] pc;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected actual_pc4=%h required=none", id_pc_plus4);
            end else begin
                pc = exp_q.pop_front();
                if (id_instr !== mem_word(pc) || id_pc_plus4 !== pc + 32'd4) begin
                    failures++;
                    $display("FAIL sb_entry actual=%h/%h required=%h/%h",
                             id_instr, id_pc_plus4, mem_word(pc), pc + 32'd4);
                end
            end
        end
    end

    initial begin
        checks         = 0;
        failures       = 0;
        rst            = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        id_ready       = 1'b0;

        // Reset state.
        #2;
        chk("rst_valid", 32'(id_valid), 32'd0);
        chk("rst_instr", id_instr, 32'd0);
        chk("rst_pc4", id_pc_plus4, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_count", 32'(count), 32'd0);

        // Streaming: one instruction per cycle, count steady at 1.
        do_reset();
        id_ready = 1'b1;
        chk("empty_no_valid", 32'(id_valid), 32'd0);
        for (int i = 0; i < 7; i++) exp_q.push_back(32'(i * 4));
        for (int i = 0; i < 8; i++) begin
            step();
            chk("stream_count", 32'(count), 32'd1);
        end
        id_ready = 1'b0;
        sb_drained("stream_drain");

        // Stall fill: count 1,2,3,4,4,4 then PC holds.
        do_reset();
        for (int i = 1; i <= 6; i++) begin
            step();
            chk("fill_count", 32'(count), 32'(i < 4 ? i : 4));
        end
        chk("full_addr", imem_addr, 32'd16);
        chk("full_head_pc4", id_pc_plus4, 32'd4);
        chk("full_head_instr", id_instr, mem_word(32'd0));

        // Drain from full while fetch continues; count stays at DEPTH.
        for (int i = 0; i < 6; i++) exp_q.push_back(32'(i * 4));
        id_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("drain_count", 32'(count), 32'd4);
        end
        id_ready = 1'b0;
        chk("drain_addr", imem_addr, 32'd40);
        sb_drained("drain_order");

        // Redirect from a full queue.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        id_ready       = 1'b1;
        #1;
        chk("redir_valid_low", 32'(id_valid), 32'd0);
        exp_q.push_back(32'h100);
        step();
        redirect_valid = 1'b0;
        chk("redir_count", 32'(count), 32'd0);
        chk("redir_addr", imem_addr, 32'h100);
        chk("redir_still_invalid", 32'(id_valid), 32'd0);
        step();
        chk("redir_first_pc4", id_pc_plus4, 32'h104);
        step();
        id_ready = 1'b0;
        sb_drained("redir_drain");

        // Back-to-back redirects: only the second target stream appears.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        id_ready       = 1'b1;
        step();
        redirect_pc = 32'h300;
        chk("b2b_addr_first", imem_addr, 32'h200);
        chk("b2b_valid_low", 32'(id_valid), 32'd0);
        step();
        redirect_valid = 1'b0;
        chk("b2b_addr_last", imem_addr, 32'h300);
        exp_q.push_back(32'h300);
        exp_q.push_back(32'h304);
        exp_q.push_back(32'h308);
        for (int i = 0; i < 4; i++) step();
        id_ready = 1'b0;
        sb_drained("b2b_drain");

        // Mid-stream asynchronous reset with three entries queued.
        step();
        step();
        chk("pre_rst_count", 32'(count), 32'd3);
        #1;
        rst = 1'b0;
        #1;
        chk("async_valid", 32'(id_valid), 32'd0);
        chk("async_count", 32'(count), 32'd0);
        chk("async_addr", imem_addr, 32'd0);
        chk("async_instr", id_instr, 32'd0);
        chk("async_pc4", id_pc_plus4, 32'd0);
        #5;
        rst = 1'b1;
        step();
        chk("restart_count", 32'(count), 32'd1);
        chk("restart_addr", imem_addr, 32'd4);
        chk("restart_pc4", id_pc_plus4, 32'd4);
        chk("restart_instr", id_instr, mem_word(32'd0));

        // PC wraps from the top of the address space to zero.
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        id_ready       = 1'b1;
        step();
        redirect_valid = 1'b0;
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0);
        step();
        chk("wrap_pc4", id_pc_plus4, 32'd0);
        step();
        step();
        id_ready = 1'b0;
        sb_drained("wrap_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
